// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage register: control-field layout,
// default control width and a saturating counter helper.
package pipe_pkg;

    // Default width of the opaque control field carried by each stage.
    localparam int CTRL_W = 12;

    // Full decoded control bundle. It spans 13 bits, so a core carrying every
    // field instantiates the stage register with CTRL_W = CTRL_FIELDS_W.
    typedef struct packed {
        logic       reg_write;
        logic [1:0] mem_to_reg;
        logic       branch;
        logic       mem_read;
        logic       mem_write;
        logic       jump;
        logic [1:0] reg_dst;
        logic       alu_src;
        logic [2:0] alu_op;
    } ctrl_fields_t;

    localparam int CTRL_FIELDS_W  = $bits(ctrl_fields_t);
    localparam int ALU_OP_LSB     = 0;
    localparam int ALU_SRC_BIT    = 3;
    localparam int REG_DST_LSB    = 4;
    localparam int JUMP_BIT       = 6;
    localparam int MEM_WRITE_BIT  = 7;
    localparam int MEM_READ_BIT   = 8;
    localparam int BRANCH_BIT     = 9;
    localparam int MEM_TO_REG_LSB = 10;
    localparam int REG_WRITE_BIT  = 12;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/pipe_stage_slot.sv
// One pipeline stage: valid/ctrl/payload registers with hold, kill and
// optional payload clearing on kill.
module pipe_stage_slot #(
    parameter int CTRL_W     = 12,
    parameter int DATA_W     = 192,
    parameter bit CLEAR_DATA = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hold,
    input  logic              kill,
    input  logic              valid_d,
    input  logic [CTRL_W-1:0] ctrl_d,
    input  logic [DATA_W-1:0] data_d,
    output logic              valid_q,
    output logic [CTRL_W-1:0] ctrl_q,
    output logic [DATA_W-1:0] data_q
);

    // NOTE: non-blocking assignments so each stage samples its neighbour's pre-edge value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            data_q  <= '0;
        end else if (kill) begin
            // Kill wins over hold; the payload still tracks the normal capture path.
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            if (CLEAR_DATA)
                data_q <= '0;
            else if (!hold)
                data_q <= data_d;
        end else if (!hold) begin
            valid_q <= valid_d;
            ctrl_q  <= valid_d ? ctrl_d : '0;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Parameterised chain of pipeline stage slots with per-stage kill, global
// stall, occupancy count and a saturating bubble counter on stage 0.
module pipe_stage_reg #(
    parameter int CTRL_W     = pipe_pkg::CTRL_W,
    parameter int DATA_W     = 192,
    parameter int DEPTH      = 1,
    parameter bit CLEAR_DATA = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       stall,
    input  logic [DEPTH-1:0]           kill,
    input  logic                       valid_in,
    input  logic [CTRL_W-1:0]          ctrl_in,
    input  logic [DATA_W-1:0]          data_in,
    output logic                       valid_out,
    output logic [CTRL_W-1:0]          ctrl_out,
    output logic [DATA_W-1:0]          data_out,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic [15:0]                bubble_cnt
);

    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]  stage_valid;
    logic [CTRL_W-1:0] stage_ctrl [DEPTH];
    logic [DATA_W-1:0] stage_data [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic              valid_d;
        logic [CTRL_W-1:0] ctrl_d;
        logic [DATA_W-1:0] data_d;

        if (i == 0) begin : g_head
            assign valid_d = valid_in;
            assign ctrl_d  = ctrl_in;
            assign data_d  = data_in;
        end else begin : g_body
            assign valid_d = stage_valid[i-1];
            assign ctrl_d  = stage_ctrl[i-1];
            assign data_d  = stage_data[i-1];
        end

        pipe_stage_slot #(
            .CTRL_W    (CTRL_W),
            .DATA_W    (DATA_W),
            .CLEAR_DATA(CLEAR_DATA)
        ) u_slot (
            .clk    (clk),
            .rst    (rst),
            .hold   (stall),
            .kill   (kill[i]),
            .valid_d(valid_d),
            .ctrl_d (ctrl_d),
            .data_d (data_d),
            .valid_q(stage_valid[i]),
            .ctrl_q (stage_ctrl[i]),
            .data_q (stage_data[i])
        );
    end

    assign valid_out = stage_valid[DEPTH-1];
    assign ctrl_out  = stage_ctrl[DEPTH-1];
    assign data_out  = stage_data[DEPTH-1];

    always_comb begin
        occupancy = '0;
        for (int i = 0; i < DEPTH; i++)
            occupancy = occupancy + OCC_W'(stage_valid[i]);
    end

    // A stalled stage 0 captures nothing, so a kill under stall is not a new bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            bubble_cnt <= '0;
        else if (!stall && (!valid_in || kill[0]))
            bubble_cnt <= pipe_pkg::sat_inc16(bubble_cnt);
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: four instances (DEPTH 3, 3 with payload
// clearing, 2 and 1) share one stimulus stream with hand-computed expectations.
module tb_pipe_stage_reg;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        valid_in;
    logic [11:0] ctrl_in;
    logic [31:0] data_in;
    logic [2:0]  kill3;
    logic [1:0]  kill2;
    logic [0:0]  kill1;

    logic        u3_valid, u3c_valid, u2_valid, u1_valid;
    logic [11:0] u3_ctrl, u3c_ctrl, u2_ctrl, u1_ctrl;
    logic [31:0] u3_data, u3c_data, u2_data, u1_data;
    logic [1:0]  u3_occ, u3c_occ, u2_occ;
    logic [0:0]  u1_occ;
    logic [15:0] u3_bub, u3c_bub, u2_bub, u1_bub;

    // Expected bubble counts, one per distinct kill stream.
    logic [15:0] bub3, bub2, bub1;

    int checks = 0;
    int errors = 0;

    pipe_stage_reg #(.CTRL_W(12), .DATA_W(32), .DEPTH(3), .CLEAR_DATA(1'b0)) u3 (
        .clk(clk), .rst(rst), .stall(stall), .kill(kill3), .valid_in(valid_in),
        .ctrl_in(ctrl_in), .data_in(data_in), .valid_out(u3_valid), .ctrl_out(u3_ctrl),
        .data_out(u3_data), .occupancy(u3_occ), .bubble_cnt(u3_bub));

    pipe_stage_reg #(.CTRL_W(12), .DATA_W(32), .DEPTH(3), .CLEAR_DATA(1'b1)) u3c (
        .clk(clk), .rst(rst), .stall(stall), .kill(kill3), .valid_in(valid_in),
        .ctrl_in(ctrl_in), .data_in(data_in), .valid_out(u3c_valid), .ctrl_out(u3c_ctrl),
        .data_out(u3c_data), .occupancy(u3c_occ), .bubble_cnt(u3c_bub));

    pipe_stage_reg #(.CTRL_W(12), .DATA_W(32), .DEPTH(2), .CLEAR_DATA(1'b0)) u2 (
        .clk(clk), .rst(rst), .stall(stall), .kill(kill2), .valid_in(valid_in),
        .ctrl_in(ctrl_in), .data_in(data_in), .valid_out(u2_valid), .ctrl_out(u2_ctrl),
        .data_out(u2_data), .occupancy(u2_occ), .bubble_cnt(u2_bub));

    pipe_stage_reg #(.CTRL_W(12), .DATA_W(32), .DEPTH(1), .CLEAR_DATA(1'b0)) u1 (
        .clk(clk), .rst(rst), .stall(stall), .kill(kill1), .valid_in(valid_in),
        .ctrl_in(ctrl_in), .data_in(data_in), .valid_out(u1_valid), .ctrl_out(u1_ctrl),
        .data_out(u1_data), .occupancy(u1_occ), .bubble_cnt(u1_bub));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] sat16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Advance one clock edge, updating the expected bubble counts from the
    // inputs presented at that edge; outputs are sampled 1 time unit later.
    task automatic tick();
        if (rst) begin
            bub3 = '0; bub2 = '0; bub1 = '0;
        end else if (!stall) begin
            if (!valid_in || kill3[0]) bub3 = sat16(bub3);
            if (!valid_in || kill2[0]) bub2 = sat16(bub2);
            if (!valid_in || kill1[0]) bub1 = sat16(bub1);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] d);
        valid_in = 1'b1;
        data_in  = d;
        tick();
    endtask

    initial begin
        int lo, hi, exp_occ;
        rst = 1'b1; stall = 1'b0; valid_in = 1'b0; ctrl_in = 12'hABC; data_in = '0;
        kill3 = '0; kill2 = '0; kill1 = '0;
        bub3 = '0; bub2 = '0; bub1 = '0;
        tick();
        tick();
        check("reset_valid", 32'(u3_valid), 0);
        check("reset_occ",   32'(u3_occ), 0);
        check("reset_bub",   32'(u3_bub), 0);
        check("reset_u1",    32'(u1_valid), 0);
        rst = 1'b0;

        // Stream of 5 valid entries through DEPTH=3, then bubbles with nonzero ctrl_in.
        for (int e = 0; e < 8; e++) begin
            valid_in = (e < 5);
            ctrl_in  = 12'hABC;
            data_in  = 32'(e + 1);
            tick();
            if (e >= 2 && e - 2 < 5) begin
                check("stream_valid", 32'(u3_valid), 1);
                check("stream_ctrl",  32'(u3_ctrl), 'hABC);
                check("stream_data",  u3_data, 32'(e - 1));
            end else begin
                check("stream_bubble_valid", 32'(u3_valid), 0);
                check("stream_bubble_ctrl",  32'(u3_ctrl), 0);
            end
            lo = (e - 2 > 0) ? e - 2 : 0;
            hi = (e < 4) ? e : 4;
            exp_occ = (hi >= lo) ? hi - lo + 1 : 0;
            check("stream_occ", 32'(u3_occ), 32'(exp_occ));
        end
        check("stream_bub", 32'(u3_bub), 3);

        // DEPTH=2 held for 4 stalled cycles with both stages valid.
        ctrl_in = 12'h123;
        push(32'h11);
        push(32'h22);
        check("fill2_occ", 32'(u2_occ), 2);
        stall = 1'b1;
        valid_in = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("stall2_valid", 32'(u2_valid), 1);
            check("stall2_ctrl",  32'(u2_ctrl), 'h123);
            check("stall2_data",  u2_data, 32'h11);
            check("stall2_occ",   32'(u2_occ), 2);
            check("stall2_bub",   32'(u2_bub), 32'(bub2));
        end
        stall = 1'b0;
        tick();
        check("unstall2_data", u2_data, 32'h22);
        check("unstall2_occ",  32'(u2_occ), 1);

        // DEPTH=3 kill of stage 0 while stalled.
        ctrl_in = 12'hABC;
        push(32'h31);
        push(32'h32);
        push(32'h33);
        check("fill3_occ", 32'(u3_occ), 3);
        stall = 1'b1; kill3 = 3'b001; data_in = 32'h99;
        tick();
        check("stallkill_valid", 32'(u3_valid), 1);
        check("stallkill_data",  u3_data, 32'h31);
        check("stallkill_occ",   32'(u3_occ), 2);
        check("stallkill_bub",   32'(u3_bub), 32'(bub3));
        stall = 1'b0; kill3 = 3'b000; valid_in = 1'b0;
        tick();
        check("after_stallkill_data", u3_data, 32'h32);
        check("after_stallkill_occ",  32'(u3_occ), 1);
        tick();
        check("killed_valid",      32'(u3_valid), 0);
        check("killed_ctrl",       32'(u3_ctrl), 0);
        check("killed_data_keep",  u3_data, 32'h33);
        check("killed_data_clear", u3c_data, 0);
        check("killed_valid_c",    32'(u3c_valid), 0);

        // DEPTH=3 kill of stages 1 and 2 while advancing.
        push(32'h41);
        push(32'h42);
        push(32'h43);
        kill3 = 3'b110; data_in = 32'h44;
        tick();
        check("kill110_valid",      32'(u3_valid), 0);
        check("kill110_ctrl",       32'(u3_ctrl), 0);
        check("kill110_data_keep",  u3_data, 32'h42);
        check("kill110_data_clear", u3c_data, 0);
        check("kill110_ctrl_c",     32'(u3c_ctrl), 0);
        check("kill110_occ",        32'(u3_occ), 1);
        check("kill110_occ_c",      32'(u3c_occ), 1);
        kill3 = 3'b000; valid_in = 1'b0;
        tick();
        check("kill110_s1_data_keep",  u3_data, 32'h43);
        check("kill110_s1_data_clear", u3c_data, 0);
        check("kill110_s1_valid",      32'(u3_valid), 0);
        tick();
        check("kill110_next_valid", 32'(u3_valid), 1);
        check("kill110_next_ctrl",  32'(u3_ctrl), 'hABC);
        check("kill110_next_data",  u3c_data, 32'h44);
        check("kill110_bub_c",      32'(u3c_bub), 32'(bub3));

        // Asynchronous reset between edges with the pipe full, mid-stall and mid-kill.
        push(32'h51);
        push(32'h52);
        push(32'h53);
        stall = 1'b1; kill3 = 3'b010;
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_valid", 32'(u3_valid), 0);
        check("async_rst_ctrl",  32'(u3_ctrl), 0);
        check("async_rst_data",  u3_data, 0);
        check("async_rst_occ",   32'(u3_occ), 0);
        check("async_rst_bub",   32'(u3_bub), 0);
        check("async_rst_u1",    32'(u1_data), 0);
        bub3 = '0; bub2 = '0; bub1 = '0;
        #2;
        rst = 1'b0; stall = 1'b0; kill3 = 3'b000;

        // DEPTH=1 behaves as a single register with kill as flush.
        push(32'h61);
        check("d1_valid", 32'(u1_valid), 1);
        check("d1_ctrl",  32'(u1_ctrl), 'hABC);
        check("d1_data",  u1_data, 32'h61);
        check("d1_occ",   32'(u1_occ), 1);
        check("d1_u3_occ", 32'(u3_occ), 1);
        kill1 = 1'b1;
        push(32'h62);
        check("d1_flush_valid", 32'(u1_valid), 0);
        check("d1_flush_ctrl",  32'(u1_ctrl), 0);
        check("d1_flush_data",  u1_data, 32'h62);
        check("d1_flush_occ",   32'(u1_occ), 0);
        check("d1_flush_bub",   32'(u1_bub), 1);
        kill1 = 1'b0;

        // Bubble counter saturation.
        #1 rst = 1'b1;
        #1 rst = 1'b0;
        bub3 = '0; bub2 = '0; bub1 = '0;
        valid_in = 1'b0;
        for (int k = 0; k < 65534; k++) tick();
        check("bub_preload", 32'(u1_bub), 32'hFFFE);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("bub_sat", 32'(u1_bub), 32'hFFFF);
        end
        check("bub_sat_u2", 32'(u2_bub), 32'(bub2));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter CTRL_W, default 12: width of the control field (WB/MEM/EX control bits); zeroed on kill.
REQ-002 Parameter DATA_W, default 192: width of the payload field (addresses, operands, immediate, register IDs, funct).
REQ-003 Parameter DEPTH, default 1, legal 1..4: number of register stages in series.
REQ-004 Parameter CLEAR_DATA, default 0: 1 means a kill also zeroes payload; 0 means payload is left as captured.
REQ-005 clk  in  1  single clock; all state updates on the rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 stall  in  1  hold all stages this cycle.
REQ-008 kill  in  DEPTH  per-stage bubble request; bit i converts the entry landing in or held in stage i into a bubble.
REQ-009 valid_in  in  1  the incoming entry is a real instruction.
REQ-010 ctrl_in  in  CTRL_W  incoming control field.
REQ-011 data_in  in  DATA_W  incoming payload.
REQ-012 valid_out  out  1  last-stage valid.
REQ-013 ctrl_out  out  CTRL_W  last-stage control.
REQ-014 data_out  out  DATA_W  last-stage payload.
REQ-015 occupancy  out  $clog2(DEPTH+1)  number of valid stages.
REQ-016 bubble_cnt  out  16  saturating count of bubbles entering stage 0.

Function
REQ-017 Per-edge priority SHALL be: rst > kill[i] > stall > advance.
REQ-018 With stall=0, stage 0 SHALL capture {valid_in, ctrl_in, data_in}, and stage i (i≥1) SHALL capture stage i-1.
REQ-019 With stall=1, every stage SHALL hold its value, except stages with kill[i]=1.
REQ-020 kill[i]=1 SHALL set stage i valid=0 and ctrl=0 after the edge, whether or not stall is asserted; payload SHALL be zeroed only when CLEAR_DATA=1.
REQ-021 A stage whose valid is 0 after capture SHALL also carry ctrl=0; an entry arriving with valid_in=0 SHALL be stored with ctrl=0 regardless of ctrl_in.
REQ-022 Latency: an entry captured at edge n SHALL appear on the outputs after edge n+DEPTH-1, plus one edge for each stalled cycle.
REQ-023 Outputs SHALL be driven directly from last-stage registers, with no combinational path from any input.
REQ-024 occupancy SHALL equal the popcount of the stage valid bits after each edge.
REQ-025 bubble_cnt SHALL increment by 1 on each edge where stall=0 and stage 0 captures a bubble (valid_in=0 or kill[0]=1), and SHALL saturate at 16'hFFFF.
REQ-026 With stall=1, bubble_cnt SHALL NOT increment, even when kill[0]=1.
REQ-027 With DEPTH=1, the block SHALL behave as a single ID/EX-style register with kill[0] as the flush input.

Reset
REQ-028 Asserting rst SHALL immediately force every stage valid, ctrl and payload to 0, with occupancy=0 and bubble_cnt=0, independent of clk.
REQ-029 Reset asserted mid-stall or mid-kill SHALL discard all in-flight entries; the first edge after rst deasserts SHALL follow REQ-017..REQ-026 normally.

Structure
REQ-030 Package pipe_pkg SHALL hold the shared control-field bit positions (RegWrite, MemtoReg[1:0], Branch, MemRead, MemWrite, Jump, RegDst[1:0], ALUSrc, ALUOp[2:0]) and the CTRL_W constant.
REQ-031 One sub-module pipe_stage_slot (one stage: valid/ctrl/data, with hold, kill and clear-data inputs) SHALL be instantiated DEPTH times in a generate loop.
REQ-032 Occupancy and bubble counting SHALL live in the top level.

Verification
REQ-033 DEPTH=3, stream 5 valid entries with ctrl=12'hABC and data=i, no stall -> each entry appears 2 edges after capture in order, and occupancy reaches 3.
REQ-034 DEPTH=2, stall=1 for 4 cycles with both stages valid -> outputs and occupancy stay constant, and bubble_cnt is unchanged.
REQ-035 DEPTH=3, stall=1 with kill=3'b001 for one cycle -> stage 0 becomes valid=0/ctrl=0, the other stages hold, and bubble_cnt is unchanged.
REQ-036 DEPTH=3, CLEAR_DATA=0, kill=3'b110 with stall=0 -> the entries landing in stages 1 and 2 carry ctrl=0 and valid=0 with payload preserved; the same test with CLEAR_DATA=1 -> payload is 0.
REQ-037 Preload bubble_cnt to 16'hFFFE, then apply 3 edges with valid_in=0 -> the count reads FFFF and stays there.
REQ-038 Assert rst asynchronously between edges with the pipe full -> all outputs are 0 before the next edge.
